// File: rtl/dense_mac_engine.sv
// Fully connected layer engine: sequences weight/activation reads per output
// neuron, accumulates products and emits a biased, saturated, optional-ReLU result.
module dense_mac_engine #(
    parameter int DATSIZE = 22,
    parameter int PARSIZE = 16,
    parameter int FPSHIFT = 14,
    parameter int ACCW    = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         state_in,
    input  logic               relu_en,
    output logic               busy,
    output logic               done,
    output logic [3:0]         layer_state,
    output logic               w_en,
    output logic [6:0]         read_o,
    output logic [7:0]         read_i,
    input  logic [PARSIZE-1:0] w_data,
    input  logic [PARSIZE-1:0] b_data,
    output logic [7:0]         act_addr,
    input  logic [DATSIZE-1:0] act_data,
    output logic               out_valid,
    output logic [6:0]         out_idx,
    output logic [DATSIZE-1:0] out_data
);

    // state | meaning
    // IDLE  | waiting for a start with a valid layer code
    // ISSUE | one weight/activation read per cycle, index 0..N_in-1
    // DRAIN | two cycles for the read latency and the two pipeline stages
    // OUT   | accumulator final; bias, shift, saturate, ReLU and register result

    localparam int PRODW = DATSIZE + PARSIZE;
    localparam logic [3:0] L_DENSE2 = 4'b1000;
    localparam logic [3:0] L_DENSE1 = 4'b1001;
    localparam logic [6:0] LAST_O   = 7'd95;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [3:0]           r_layer;
    logic                 r_relu;
    logic [7:0]           r_last_i;
    logic                 r_w_en;
    logic [6:0]           r_read_o;
    logic [7:0]           r_read_i;
    logic                 r_drain_cnt;
    logic                 r_out_valid;
    logic [6:0]           r_out_idx;
    logic [DATSIZE-1:0]   r_out_data;

    logic                 r_v1, r_f1, r_v2, r_f2;
    logic signed [PRODW-1:0] r_p;
    logic signed [ACCW-1:0]  r_acc;

    logic                    w_accept;
    logic signed [PRODW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_p_ext;
    logic signed [ACCW-1:0]  w_bias_ext;
    logic signed [ACCW-1:0]  w_sum;
    logic signed [ACCW-1:0]  w_shift;
    logic                    w_ovf;
    logic [DATSIZE-1:0]      w_sat;
    logic [DATSIZE-1:0]      w_result;

    assign w_accept = start && !r_busy && (r_state == S_IDLE) &&
                      ((state_in == L_DENSE2) || (state_in == L_DENSE1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_layer     <= 4'b0000;
            r_relu      <= 1'b0;
            r_last_i    <= 8'd0;
            r_w_en      <= 1'b0;
            r_read_o    <= 7'd0;
            r_read_i    <= 8'd0;
            r_drain_cnt <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= 7'd0;
            r_out_data  <= '0;
        end else begin
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // busy stays up through the done cycle, which is spent here
                    r_busy  <= 1'b0;
                    r_layer <= 4'b0000;
                    r_w_en  <= 1'b0;
                    if (w_accept) begin
                        r_state  <= S_ISSUE;
                        r_busy   <= 1'b1;
                        r_layer  <= state_in;
                        r_relu   <= relu_en;
                        r_last_i <= (state_in == L_DENSE2) ? 8'd255 : 8'd95;
                        r_read_o <= 7'd0;
                        r_read_i <= 8'd0;
                        r_w_en   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_read_i == r_last_i) begin
                        r_w_en      <= 1'b0;
                        r_drain_cnt <= 1'b1;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_read_i <= r_read_i + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == 1'b0) begin
                        r_state <= S_OUT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                S_OUT: begin
                    r_out_valid <= 1'b1;
                    r_out_idx   <= r_read_o;
                    r_out_data  <= w_result;
                    r_read_i    <= 8'd0;
                    if (r_read_o == LAST_O) begin
                        r_done   <= 1'b1;
                        r_layer  <= 4'b0000;
                        r_read_o <= 7'd0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_read_o <= r_read_o + 7'd1;
                        r_w_en   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_prod  = $signed(w_data) * $signed(act_data);
    assign w_p_ext = {{(ACCW-PRODW){r_p[PRODW-1]}}, r_p};

    // Valid/first travel alongside the read data; "first" restarts the sum
    // so back-to-back neurons need no clearing bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_f1  <= 1'b0;
            r_v2  <= 1'b0;
            r_f2  <= 1'b0;
            r_p   <= '0;
            r_acc <= '0;
        end else begin
            r_v1 <= r_w_en;
            r_f1 <= r_w_en && (r_read_i == 8'd0);
            r_v2 <= r_v1;
            r_f2 <= r_f1;
            if (r_v1) begin
                r_p <= w_prod;
            end
            if (r_v2) begin
                r_acc <= r_f2 ? w_p_ext : (r_acc + w_p_ext);
            end
        end
    end

    assign w_bias_ext = {{(ACCW-PARSIZE){b_data[PARSIZE-1]}}, b_data};
    assign w_sum      = r_acc + (w_bias_ext <<< FPSHIFT);
    assign w_shift    = w_sum >>> FPSHIFT;

    // In range only when every bit above the result sign bit matches it.
    assign w_ovf = !((&w_shift[ACCW-1:DATSIZE-1]) || !(|w_shift[ACCW-1:DATSIZE-1]));

    always_comb begin
        w_sat = w_shift[DATSIZE-1:0];
        if (w_ovf) begin
            w_sat = w_shift[ACCW-1] ? {1'b1, {(DATSIZE-1){1'b0}}}
                                    : {1'b0, {(DATSIZE-1){1'b1}}};
        end
    end

    assign w_result = (r_relu && w_sat[DATSIZE-1]) ? '0 : w_sat;

    assign busy        = r_busy;
    assign done        = r_done;
    assign layer_state = r_layer;
    assign w_en        = r_w_en;
    assign read_o      = r_read_o;
    assign read_i      = r_read_i;
    assign act_addr    = r_read_i;
    assign out_valid   = r_out_valid;
    assign out_idx     = r_out_idx;
    assign out_data    = r_out_data;

endmodule
